mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arb_prio.sv | 55 +++++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared types and defaults for the memory arbiter.
//   state_e        : arbiter FSM states (IDLE, FETCH, LOAD, STORE)
//   gnt_e          : grant type produced by the priority selector
//   STARVE_MAX_DEF : default max consecutive data grants while a fetch waits
//   TIMEOUT_DEF    : default mem_ack timeout in mem_req cycles
//   gnt_to_state() : maps a grant to the FSM state that serves it
package mem_arbiter_pkg;

  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;

  // IDLE must encode to zero so the reset state is all-zeros.
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_LOAD, GNT_STORE} gnt_e;

  function automatic state_e gnt_to_state(gnt_e g);
    case (g)
      GNT_FETCH: return FETCH;
      GNT_LOAD:  return LOAD;
      GNT_STORE: return STORE;
      default:   return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio -- grant selection with fetch anti-starvation.
//   clk, reset   : clock, synchronous active-high reset
//   i_arb_en     : arbiter is idle and may grant this cycle
//   i_fetch_req  : instruction fetch request
//   i_load_req   : data load request
//   i_store_req  : data store request
//   o_gnt        : combinational grant (GNT_NONE when not enabled or no request)
// Normal priority is store > load > fetch. A waiting fetch overrides the data
// ports once it has watched STARVE_MAX data grants go by.
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_arb_en,
  input  logic i_fetch_req,
  input  logic i_load_req,
  input  logic i_store_req,
  output gnt_e o_gnt
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          w_starved;
  logic          w_data_gnt;

  assign w_starved  = i_fetch_req && (r_starve_cnt == CW'(STARVE_MAX));
  assign w_data_gnt = (o_gnt == GNT_LOAD) || (o_gnt == GNT_STORE);

  always_comb begin
    o_gnt = GNT_NONE;
    if (i_arb_en) begin
      if (w_starved)        o_gnt = GNT_FETCH;
      else if (i_store_req) o_gnt = GNT_STORE;
      else if (i_load_req)  o_gnt = GNT_LOAD;
      else if (i_fetch_req) o_gnt = GNT_FETCH;
    end
  end

  // Counts only data grants that happen while a fetch is actually waiting;
  // any cycle without a fetch request forgets the history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!i_fetch_req || (o_gnt == GNT_FETCH)) begin
      r_starve_cnt <= '0;
    end else if (w_data_gnt && (r_starve_cnt != CW'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates fetch, load and store onto one memory port.
//   clk, reset                 : clock, synchronous active-high reset
//   inst_*                     : fetch request/address, valid pulse and read data
//   dmem_read_*                : load request/address, valid pulse and read data
//   dmem_write_*               : store request/address/data/byte enables, valid pulse
//   mem_*                      : memory bus (req/we/addr/wdata/be out, ack/rdata in)
//   stall                      : some request is pending without its valid pulse
//   exception                  : one-cycle bus timeout pulse
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to add a mem_ack timeout;
// without it exception is tied low and the FSM waits for mem_ack forever.
// Timing: grant in IDLE, one or more mem_req cycles ending on mem_ack, then
// the valid pulse in the following (IDLE) cycle, where a new grant may occur.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_valid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                dmem_read_ready,
  input  logic [ADDR_W-1:0]   dmem_read_address,
  output logic                dmem_read_valid,
  output logic [DATA_W-1:0]   dmem_read_data,
  input  logic                dmem_write_ready,
  input  logic [ADDR_W-1:0]   dmem_write_address,
  input  logic [DATA_W-1:0]   dmem_write_data,
  input  logic [DATA_W/8-1:0] dmem_write_byte,
  output logic                dmem_write_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                exception
);

  localparam int BE_W = DATA_W / 8;

  state_e              r_state, w_next;
  gnt_e                w_gnt;
  logic                w_arb_en;
  logic                w_timeout;
  logic                w_done;
  logic [DATA_W-1:0]   w_rdata;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic                r_inst_valid, r_load_valid, r_store_valid;
  logic [DATA_W-1:0]   r_inst_rdata, r_load_rdata;

  assign w_arb_en = (r_state == IDLE);

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk         (clk),
    .reset       (reset),
    .i_arb_en    (w_arb_en),
    .i_fetch_req (inst_req),
    .i_load_req  (dmem_read_ready),
    .i_store_req (dmem_write_ready),
    .o_gnt       (w_gnt)
  );

  // A timed-out read completes with zero data.
  assign w_done  = (r_state != IDLE) && (mem_ack || w_timeout);
  assign w_rdata = mem_ack ? mem_rdata : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = gnt_to_state(w_gnt);
      default: if (w_done) w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_inst_valid  <= 1'b0;
      r_load_valid  <= 1'b0;
      r_store_valid <= 1'b0;
      r_inst_rdata  <= '0;
      r_load_rdata  <= '0;
    end else begin
      r_state <= w_next;
      // Bus fields are latched at grant so the requester may change or drop
      // its inputs while the transaction is in flight.
      case (w_gnt)
        GNT_STORE: begin
          r_addr  <= dmem_write_address;
          r_wdata <= dmem_write_data;
          r_be    <= dmem_write_byte;
        end
        GNT_LOAD: begin
          r_addr  <= dmem_read_address;
          r_wdata <= '0;
          r_be    <= '1;
        end
        GNT_FETCH: begin
          r_addr  <= inst_addr;
          r_wdata <= '0;
          r_be    <= '1;
        end
        default: ;
      endcase
      r_inst_valid  <= w_done && (r_state == FETCH);
      r_load_valid  <= w_done && (r_state == LOAD);
      r_store_valid <= w_done && (r_state == STORE);
      if (w_done && (r_state == FETCH)) r_inst_rdata <= w_rdata;
      if (w_done && (r_state == LOAD))  r_load_rdata <= w_rdata;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_timer;
  logic          r_exception;

  // r_timer equals the number of completed mem_req cycles of this transaction.
  assign w_timeout = (r_state != IDLE) && !mem_ack && (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer     <= '0;
      r_exception <= 1'b0;
    end else begin
      r_exception <= w_timeout;
      r_timer     <= (r_state == IDLE) ? '0 : r_timer + 1'b1;
    end
  end

  assign exception = r_exception;
`else
  assign w_timeout = 1'b0;
  assign exception = 1'b0;
`endif

  assign mem_req          = (r_state != IDLE);
  assign mem_we           = (r_state == STORE);
  assign mem_addr         = r_addr;
  assign mem_wdata        = r_wdata;
  assign mem_be           = r_be;
  assign inst_valid       = r_inst_valid;
  assign inst_rdata       = r_inst_rdata;
  assign dmem_read_valid  = r_load_valid;
  assign dmem_read_data   = r_load_rdata;
  assign dmem_write_valid = r_store_valid;

  // A request stops stalling in the cycle its valid pulses.
  assign stall = !reset && ((inst_req         && !r_inst_valid) ||
                            (dmem_read_ready  && !r_load_valid) ||
                            (dmem_write_ready && !r_store_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed scenarios followed by random traffic, all
// checked each cycle against a transaction-level model of the arbiter.
// Define MEM_ARBITER_TIMEOUT_EN for both bench and RTL to cover the timeout.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SM = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_valid;
  logic [DW-1:0] inst_rdata;
  logic          dmem_read_ready;
  logic [AW-1:0] dmem_read_address;
  logic          dmem_read_valid;
  logic [DW-1:0] dmem_read_data;
  logic          dmem_write_ready;
  logic [AW-1:0] dmem_write_address;
  logic [DW-1:0] dmem_write_data;
  logic [BW-1:0] dmem_write_byte;
  logic          dmem_write_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall;
  logic          exception;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid), .inst_rdata(inst_rdata),
    .dmem_read_ready(dmem_read_ready), .dmem_read_address(dmem_read_address),
    .dmem_read_valid(dmem_read_valid), .dmem_read_data(dmem_read_data),
    .dmem_write_ready(dmem_write_ready), .dmem_write_address(dmem_write_address),
    .dmem_write_data(dmem_write_data), .dmem_write_byte(dmem_write_byte),
    .dmem_write_valid(dmem_write_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .exception(exception)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: kinds 0=fetch 1=load 2=store.
  bit            m_busy;
  int            m_kind;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  int            m_starve;
  int            m_wait;
  int            m_tcnt;
  bit [2:0]      e_vld;
  logic [DW-1:0] e_irdata, e_drdata;
  bit            e_exc;

  // Memory responder control: 0 = ack after ack_lat busy cycles, 1 = ack held high, 2 = never ack.
  int            ack_mode;
  int            ack_lat;
  logic [DW-1:0] ack_data;

  logic [AW-1:0] obs_addr[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic cycle();
    bit [2:0]      nv;
    bit            done, texp, starved;
    int            k;
    logic [DW-1:0] rd;
    case (ack_mode)
      1:       mem_ack = 1'b1;
      2:       mem_ack = 1'b0;
      default: mem_ack = m_busy && (m_wait >= ack_lat);
    endcase
    mem_rdata = ack_data;
    #2;
    chk("inst_valid", inst_valid, e_vld[0]);
    chk("dmem_read_valid", dmem_read_valid, e_vld[1]);
    chk("dmem_write_valid", dmem_write_valid, e_vld[2]);
    chk("inst_rdata", inst_rdata, e_irdata);
    chk("dmem_read_data", dmem_read_data, e_drdata);
    chk("mem_req", mem_req, m_busy);
    chk("exception", exception, e_exc);
    chk("stall", stall, !reset && ((inst_req && !e_vld[0]) ||
                                   (dmem_read_ready && !e_vld[1]) ||
                                   (dmem_write_ready && !e_vld[2])));
    if (m_busy) begin
      chk("mem_we", mem_we, m_kind == 2);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_be", mem_be, m_be);
      if (m_kind == 2) chk("mem_wdata", mem_wdata, m_wdata);
      if (m_wait == 0) obs_addr.push_back(mem_addr);
    end
    nv = '0; texp = 1'b0;
    if (reset) begin
      m_busy = 0; m_starve = 0; m_wait = 0; m_tcnt = 0;
      e_irdata = '0; e_drdata = '0; e_vld = '0; e_exc = 0;
    end else begin
      if (m_busy) begin
        done = mem_ack;
`ifdef MEM_ARBITER_TIMEOUT_EN
        if (!mem_ack && m_tcnt == TO - 1) begin done = 1; texp = 1; end
`endif
        rd = mem_ack ? mem_rdata : '0;
        if (done) begin
          nv[m_kind] = 1'b1;
          if (m_kind == 0) e_irdata = rd;
          if (m_kind == 1) e_drdata = rd;
          m_busy = 0;
        end
        m_wait++; m_tcnt++;
      end else begin
        starved = inst_req && (m_starve == SM);
        k = -1;
        if (starved)               k = 0;
        else if (dmem_write_ready) k = 2;
        else if (dmem_read_ready)  k = 1;
        else if (inst_req)         k = 0;
        if (k >= 0) begin
          m_busy = 1; m_kind = k; m_wait = 0; m_tcnt = 0;
          m_addr  = (k == 0) ? inst_addr : (k == 1) ? dmem_read_address : dmem_write_address;
          m_be    = (k == 2) ? dmem_write_byte : '1;
          m_wdata = dmem_write_data;
          if (k == 0) m_starve = 0;
          else if (inst_req && m_starve < SM) m_starve++;
        end
      end
      if (!inst_req) m_starve = 0;
      e_vld = nv;
      e_exc = texp;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; inst_req = 0; inst_addr = '0; dmem_read_ready = 0; dmem_read_address = '0;
    dmem_write_ready = 0; dmem_write_address = '0; dmem_write_data = '0; dmem_write_byte = '0;
    mem_ack = 0; mem_rdata = '0;
    m_busy = 0; m_kind = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_starve = 0;
    m_wait = 0; m_tcnt = 0; e_vld = '0; e_irdata = '0; e_drdata = '0; e_exc = 0;
    ack_mode = 0; ack_lat = 0; ack_data = '0;
    @(posedge clk); #1;

    // Reset state, stall masked by reset even with a request present.
    inst_req = 1; cycle();
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    inst_req = 0; reset = 0;

    // mem_ack while idle is ignored.
    ack_mode = 1; cycle(); cycle(); ack_mode = 0;

    // Single fetch, ack in the first mem_req cycle: valid on cycle 3.
    inst_addr = 32'h100; ack_data = 32'h13; inst_req = 1;
    cycle(); cycle();
    chk("fetch_c3_valid", inst_valid, 1);
    chk("fetch_c3_rdata", inst_rdata, 32'h13);
    inst_req = 0; cycle();

    // Store and load together: store first, then load.
    dmem_write_ready = 1; dmem_write_address = 32'h40; dmem_write_data = 32'hDEADBEEF;
    dmem_write_byte = 4'b0011; dmem_read_ready = 1; dmem_read_address = 32'h80;
    ack_data = 32'h55AA55AA;
    cycle();
    chk("st_first_we", mem_we, 1);
    chk("st_first_be", mem_be, 4'b0011);
    chk("st_first_addr", mem_addr, 32'h40);
    cycle();
    chk("st_valid", dmem_write_valid, 1);
    dmem_write_ready = 0; cycle();
    chk("ld_second_we", mem_we, 0);
    chk("ld_second_be", mem_be, 4'hF);
    chk("ld_second_addr", mem_addr, 32'h80);
    cycle();
    chk("ld_valid", dmem_read_valid, 1);
    chk("ld_rdata", dmem_read_data, 32'h55AA55AA);
    dmem_read_ready = 0; cycle();

    // Fetch held against back-to-back loads: fetch wins the 5th arbitration.
    obs_addr.delete();
    inst_addr = 32'h200; inst_req = 1; dmem_read_address = 32'h300; dmem_read_ready = 1;
    repeat (10) begin ack_data = $urandom; cycle(); end
    chk("starve_count", obs_addr.size(), 5);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("starve_load_addr", obs_addr[i], 32'h300);
    if (obs_addr.size() > 4) chk("starve_fetch_addr", obs_addr[4], 32'h200);
    inst_req = 0; dmem_read_ready = 0;
    repeat (3) cycle();

    // Reset during a load wait.
    dmem_read_address = 32'h500; dmem_read_ready = 1; ack_mode = 2;
    cycle(); cycle();
    reset = 1; dmem_read_ready = 0; cycle();
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_valid", dmem_read_valid, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_drdata", dmem_read_data, 0);
    chk("rst_mid_irdata", inst_rdata, 0);
    reset = 0; ack_mode = 0;
    cycle(); cycle();

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Never acked: exception and zero-data valid after TO mem_req cycles.
    dmem_read_address = 32'h600; dmem_read_ready = 1; ack_mode = 2;
    cycle(); dmem_read_ready = 0;
    repeat (TO) cycle();
    chk("to_exception", exception, 1);
    chk("to_valid", dmem_read_valid, 1);
    chk("to_data", dmem_read_data, 0);
    chk("to_idle", mem_req, 0);
    ack_mode = 0; cycle();
`else
    // No timeout: waits for mem_ack indefinitely, request dropped mid-flight.
    dmem_read_address = 32'h700; dmem_read_ready = 1; ack_mode = 2;
    cycle(); dmem_read_ready = 0;
    repeat (30) cycle();
    chk("wait_req", mem_req, 1);
    ack_mode = 0; ack_lat = 0; ack_data = 32'hCAFE0001;
    cycle();
    chk("wait_valid", dmem_read_valid, 1);
    chk("wait_data", dmem_read_data, 32'hCAFE0001);
    cycle();
`endif

    // Random traffic: requests held until their valid, then re-rolled.
    repeat (400) begin
      if (!(inst_req && !e_vld[0])) begin
        inst_req = ($urandom_range(0, 2) == 0); inst_addr = $urandom;
      end
      if (!(dmem_read_ready && !e_vld[1])) begin
        dmem_read_ready = ($urandom_range(0, 2) == 0); dmem_read_address = $urandom;
      end
      if (!(dmem_write_ready && !e_vld[2])) begin
        dmem_write_ready = ($urandom_range(0, 3) == 0); dmem_write_address = $urandom;
        dmem_write_data = $urandom; dmem_write_byte = BW'($urandom);
      end
      if (!m_busy) ack_lat = $urandom_range(0, 3);
      ack_data = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
